alu_seq: RTL and testbench

- Parametrised, handshaked successor to the 16-bit ALU_TOP.
- Accepts one operation per transaction: operands A/B plus 4-bit alu_fun, same opcode map as ALU_TOP.
- Returns a registered result on one result bus, tagged with the producing unit.
- Division is iterative and multi-cycle; all other ops complete in 1 cycle. Output holds under downstream backpressure.

---
 rtl/alu_seq_pkg.sv | 24 ++
 rtl/alu_seq_div.sv | 47 ++++
 rtl/alu_seq.sv | 120 ++++++++++++
 tb/tb_alu_seq.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, result-unit tags and handshake FSM states shared by the alu_seq block
package alu_seq_pkg;
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_MUL   = 4'h2;
  localparam logic [3:0] OP_DIV   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_NAND  = 4'h6;
  localparam logic [3:0] OP_NOR   = 4'h7;
  localparam logic [3:0] OP_NOP   = 4'h8;
  localparam logic [3:0] OP_EQ    = 4'h9;
  localparam logic [3:0] OP_GT    = 4'hA;
  localparam logic [3:0] OP_LT    = 4'hB;
  localparam logic [3:0] OP_SHR_A = 4'hC;
  localparam logic [3:0] OP_SHL_A = 4'hD;
  localparam logic [3:0] OP_SHR_B = 4'hE;
  localparam logic [3:0] OP_SHL_B = 4'hF;
  localparam logic [1:0] UNIT_ARITH = 2'd0;
  localparam logic [1:0] UNIT_LOGIC = 2'd1;
  localparam logic [1:0] UNIT_CMP   = 2'd2;
  localparam logic [1:0] UNIT_SHIFT = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_HOLD} state_t;
endpackage

// File: rtl/alu_seq_div.sv
// alu_seq_div: iterative restoring unsigned divider, one quotient bit per cycle (ports: clk, rest, start, dividend, divisor, busy, done, quotient, remainder)
module alu_seq_div #(
  parameter int WIDTH     = 16,
  parameter int DIV_CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
  logic [DIV_CNT_W-1:0] cnt;
  logic [WIDTH:0] shifted, trial;
  // quotient/remainder are the outcome of the current step, so the final step's result is usable on the same edge it completes
  always_comb begin
    shifted   = {rem_q, quo_q[WIDTH-1]};
    trial     = shifted - {1'b0, dsr_q};
    quotient  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    remainder = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    done      = busy && (cnt == DIV_CNT_W'(WIDTH - 1));
  end
  always_ff @(posedge clk) begin
    if (rest) begin
      busy  <= 1'b0;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
    end else if (busy) begin
      rem_q <= remainder;
      quo_q <= quotient;
      cnt   <= done ? '0 : cnt + 1'b1;
      busy  <= ~done;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle ops and an iterative divider (ports: clk, rest, A, B, alu_fun, in_valid/in_ready, res, res_hi, carry_out, unit, err, out_valid/out_ready)
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DIV_CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rest,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       alu_fun,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             carry_out,
  output logic [1:0]       unit,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready
);
  state_t state;
  logic [WIDTH-1:0] r_c, h_c, quo, rem;
  logic [WIDTH:0] sum, diff;
  logic [2*WIDTH-1:0] prod;
  logic c_c, e_c, acc, is_div, div_busy, div_done;
  logic [1:0] u_c;
  assign in_ready = ~rest && (state == ST_IDLE) && (~out_valid || out_ready);
  assign acc      = in_valid && in_ready;
  assign is_div   = (alu_fun == OP_DIV) && (B != '0);
  assign sum      = {1'b0, A} + {1'b0, B};
  assign diff     = {1'b0, A} - {1'b0, B};
  assign prod     = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  // divide-by-zero also lands in the OP_DIV arm and completes in one cycle
  always_comb begin
    r_c = '0;
    h_c = '0;
    c_c = 1'b0;
    e_c = 1'b0;
    u_c = UNIT_ARITH;
    case (alu_fun)
      OP_ADD:   {c_c, r_c} = sum;
      OP_SUB:   {c_c, r_c} = diff;
      OP_MUL:   {h_c, r_c} = prod;
      OP_DIV:   begin r_c = '1; h_c = A; e_c = 1'b1; end
      OP_AND:   begin r_c = A & B; u_c = UNIT_LOGIC; end
      OP_OR:    begin r_c = A | B; u_c = UNIT_LOGIC; end
      OP_NAND:  begin r_c = ~(A & B); u_c = UNIT_LOGIC; end
      OP_NOR:   begin r_c = ~(A | B); u_c = UNIT_LOGIC; end
      OP_NOP:   u_c = UNIT_CMP;
      OP_EQ:    begin r_c = (A == B) ? WIDTH'(1) : '0; u_c = UNIT_CMP; end
      OP_GT:    begin r_c = (A > B) ? WIDTH'(2) : '0; u_c = UNIT_CMP; end
      OP_LT:    begin r_c = (A < B) ? WIDTH'(3) : '0; u_c = UNIT_CMP; end
      OP_SHR_A: begin r_c = A >> 1; u_c = UNIT_SHIFT; end
      OP_SHL_A: begin r_c = A << 1; u_c = UNIT_SHIFT; end
      OP_SHR_B: begin r_c = B >> 1; u_c = UNIT_SHIFT; end
      OP_SHL_B: begin r_c = B << 1; u_c = UNIT_SHIFT; end
      default:  ;
    endcase
  end
  alu_seq_div #(.WIDTH(WIDTH), .DIV_CNT_W(DIV_CNT_W)) u_div (
    .clk(clk),
    .rest(rest),
    .start(acc && is_div),
    .dividend(A),
    .divisor(B),
    .busy(div_busy),
    .done(div_done),
    .quotient(quo),
    .remainder(rem)
  );
  always_ff @(posedge clk) begin
    if (rest) begin
      state     <= ST_IDLE;
      res       <= '0;
      res_hi    <= '0;
      carry_out <= 1'b0;
      unit      <= UNIT_ARITH;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc && !is_div) begin
            res       <= r_c;
            res_hi    <= h_c;
            carry_out <= c_c;
            unit      <= u_c;
            err       <= e_c;
            out_valid <= 1'b1;
          end else if (acc) begin
            state     <= ST_DIV;
            out_valid <= 1'b0;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        ST_DIV: begin
          if (div_done && div_busy) begin
            res       <= quo;
            res_hi    <= rem;
            carry_out <= 1'b0;
            unit      <= UNIT_ARITH;
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= out_ready ? ST_IDLE : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH=16
module tb_alu_seq;
  logic clk = 1'b0, rest = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [15:0] A = '0, B = '0, res, res_hi;
  logic [3:0] alu_fun = '0;
  logic in_ready, carry_out, err, out_valid;
  logic [1:0] unit;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rest(rest), .A(A), .B(B), .alu_fun(alu_fun), .in_valid(in_valid),
    .in_ready(in_ready), .res(res), .res_hi(res_hi), .carry_out(carry_out), .unit(unit),
    .err(err), .out_valid(out_valid), .out_ready(out_ready)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    alu_fun = f;
    A = a;
    B = b;
    in_valid = 1'b1;
  endtask
  initial begin
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("rst_res", 32'(res), 32'h0);
    chk("rst_res_hi", 32'(res_hi), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_flags", {29'd0, carry_out, err, 1'b0}, 32'd0);
    chk("rst_unit", 32'(unit), 32'd0);
    rest = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    op(4'h0, 16'd3, 16'd2);
    tick();
    chk("add_res", 32'(res), 32'd5);
    chk("add_unit", 32'(unit), 32'd0);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("b2b_ready1", 32'(in_ready), 32'd1);
    op(4'h4, 16'd3, 16'd5);
    tick();
    chk("and_res", 32'(res), 32'd1);
    chk("and_unit", 32'(unit), 32'd1);
    chk("b2b_ready2", 32'(in_ready), 32'd1);
    op(4'hD, 16'd3, 16'd0);
    tick();
    chk("shl_res", 32'(res), 32'd6);
    chk("shl_unit", 32'(unit), 32'd3);
    chk("shl_valid", 32'(out_valid), 32'd1);
    op(4'h1, 16'd2, 16'd4);
    tick();
    chk("sub_res", 32'(res), 32'hFFFE);
    chk("sub_borrow", 32'(carry_out), 32'd1);
    op(4'h0, 16'hFFFF, 16'd1);
    tick();
    chk("addwrap_res", 32'(res), 32'h0);
    chk("addwrap_carry", 32'(carry_out), 32'd1);
    op(4'h2, 16'h0100, 16'h0100);
    tick();
    chk("mul_lo", 32'(res), 32'h0);
    chk("mul_hi", 32'(res_hi), 32'h0001);
    chk("mul_carry", 32'(carry_out), 32'd0);
    op(4'h3, 16'd100, 16'd7);
    tick();
    chk("div_acc_valid", 32'(out_valid), 32'd0);
    chk("div_acc_ready", 32'(in_ready), 32'd0);
    op(4'h0, 16'd9, 16'd3);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("div_busy_valid", 32'(out_valid), 32'd0);
      chk("div_busy_ready", 32'(in_ready), 32'd0);
      if (i == 14) in_valid = 1'b0;
    end
    tick();
    chk("div_valid", 32'(out_valid), 32'd1);
    chk("div_quo", 32'(res), 32'd14);
    chk("div_rem", 32'(res_hi), 32'd2);
    chk("div_err", 32'(err), 32'd0);
    op(4'h3, 16'd5, 16'd0);
    tick();
    chk("dz_res", 32'(res), 32'hFFFF);
    chk("dz_hi", 32'(res_hi), 32'd5);
    chk("dz_err", 32'(err), 32'd1);
    chk("dz_unit", 32'(unit), 32'd0);
    chk("dz_valid", 32'(out_valid), 32'd1);
    op(4'hA, 16'd3, 16'd1);
    tick();
    out_ready = 1'b0;
    op(4'h0, 16'd7, 16'd7);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_res", 32'(res), 32'd2);
      chk("bp_unit", 32'(unit), 32'd2);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp_drop_valid", 32'(out_valid), 32'd0);
    op(4'h0, 16'd7, 16'd7);
    tick();
    chk("bp_next_res", 32'(res), 32'd14);
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    op(4'h3, 16'd100, 16'd7);
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rest = 1'b1;
    tick();
    chk("mid_rst_res", 32'(res), 32'h0);
    chk("mid_rst_hi", 32'(res_hi), 32'h0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    rest = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    op(4'h0, 16'd1, 16'd1);
    tick();
    chk("post_rst_add", 32'(res), 32'd2);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
